// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared definitions for the multicycle RV64-subset main control unit:
// state encoding, supported opcodes, ALU_op and ALU source-B encodings,
// and the packed bundle of per-cycle datapath controls.
package multicycle_ctrl_fsm_pkg;

    typedef enum logic [3:0] {
        CS_RESET     = 4'd0,
        CS_FETCH     = 4'd1,
        CS_DECODE    = 4'd2,
        CS_MEM_ADDR  = 4'd3,
        CS_MEM_READ  = 4'd4,
        CS_MEM_WRITE = 4'd5,
        CS_MEM_WB    = 4'd6,
        CS_EXECUTE   = 4'd7,
        CS_ALU_WB    = 4'd8,
        CS_BRANCH    = 4'd9,
        CS_TRAP      = 4'd10
    } ctrl_state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       pc_source;
        logic       trap;
    } ctrl_sig_t;

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bus between the main control FSM (master) and the datapath
// (slave): instruction/memory status in, per-cycle enables and selects out.
interface multicycle_ctrl_fsm_if;

    logic [6:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] ctrl_ALU_op;
    logic       pc_source;
    logic       trap;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
               ir_write, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               ctrl_ALU_op, pc_source, trap
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
               ir_write, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               ctrl_ALU_op, pc_source, trap
    );

endinterface

// File: rtl/multicycle_ctrl_fsm_stall_timer.sv
// Memory stall timer (ctrl_stall_timer). Down-counter loaded with
// MEM_TIMEOUT whenever the FSM changes state, decremented on each stalled
// cycle and saturating at zero. timeout fires combinationally on the stall
// cycle that makes the consecutive-stall count reach MEM_TIMEOUT, so the
// FSM traps on the following edge. MEM_TIMEOUT = 0 disables the timeout.
module multicycle_ctrl_fsm_stall_timer #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stall,
    input  logic clear,
    output logic timeout
);

    localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LOAD = CW'(MEM_TIMEOUT);

    logic [CW-1:0] remain;

    // Reload on every state change, otherwise count down while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remain <= LOAD;
        end else if (clear) begin
            remain <= LOAD;
        end else if (stall && (remain != '0)) begin
            remain <= remain - CW'(1);
        end
    end

    assign timeout = (MEM_TIMEOUT != 0) && stall && (remain == CW'(1));

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control unit for the multicycle RV64 subset (ld, sd, R-type, beq).
// Pure Moore decode of datapath enables from the state register, except
// that FETCH qualifies ir_write/pc_write with mem_ready. Memory waits are
// bounded by MEM_TIMEOUT; illegal opcodes and timeouts park in TRAP until
// reset.
// Optional build macro: CTRL_PERF_CNT_EN adds cycle_cnt / instr_cnt
// performance counters of width CNT_W.
//
//   state      | meaning
//   -----------+----------------------------------------------------
//   S_RESET    | in/just out of reset, all outputs low
//   S_FETCH    | read instruction at PC, PC+4 on completion
//   S_DECODE   | branch target into ALUOut, dispatch on opcode
//   S_MEM_ADDR | effective address = A + imm
//   S_MEM_READ | load data access at ALUOut
//   S_MEM_WRITE| store data access at ALUOut
//   S_MEM_WB   | write MDR into register file
//   S_EXECUTE  | R-type ALU operation on A, B
//   S_ALU_WB   | write ALUOut into register file
//   S_BRANCH   | compare A - B, conditional PC load from ALUOut
//   S_TRAP     | illegal opcode or memory timeout, exit only by reset
module multicycle_ctrl_fsm
    import multicycle_ctrl_fsm_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
`ifdef CTRL_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W = 32
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_ctrl_fsm_if.master bus
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]     cycle_cnt,
    output logic [CNT_W-1:0]     instr_cnt
`endif
);

    localparam logic [3:0] S_RESET     = CS_RESET;
    localparam logic [3:0] S_FETCH     = CS_FETCH;
    localparam logic [3:0] S_DECODE    = CS_DECODE;
    localparam logic [3:0] S_MEM_ADDR  = CS_MEM_ADDR;
    localparam logic [3:0] S_MEM_READ  = CS_MEM_READ;
    localparam logic [3:0] S_MEM_WRITE = CS_MEM_WRITE;
    localparam logic [3:0] S_MEM_WB    = CS_MEM_WB;
    localparam logic [3:0] S_EXECUTE   = CS_EXECUTE;
    localparam logic [3:0] S_ALU_WB    = CS_ALU_WB;
    localparam logic [3:0] S_BRANCH    = CS_BRANCH;
    localparam logic [3:0] S_TRAP      = CS_TRAP;

    logic [3:0] state;
    logic [3:0] state_nxt;
    logic       mem_wait_state;
    logic       stall;
    logic       stall_timeout;
    ctrl_sig_t  cs;

    assign mem_wait_state = (state == S_FETCH) || (state == S_MEM_READ) ||
                            (state == S_MEM_WRITE);
    assign stall = mem_wait_state && !bus.mem_ready;

    multicycle_ctrl_fsm_stall_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_ctrl_stall_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .stall   (stall),
        .clear   (state_nxt != state),
        .timeout (stall_timeout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RESET;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: opcode and mem_ready only steer transitions.
    always_comb begin
        state_nxt = state;
        case (state)
            S_RESET:     state_nxt = S_FETCH;
            S_FETCH: begin
                if (stall_timeout)      state_nxt = S_TRAP;
                else if (bus.mem_ready) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                case (bus.opcode)
                    OP_LOAD, OP_STORE: state_nxt = S_MEM_ADDR;
                    OP_RTYPE:          state_nxt = S_EXECUTE;
                    OP_BRANCH:         state_nxt = S_BRANCH;
                    default:           state_nxt = S_TRAP;
                endcase
            end
            // IR is stable here, so re-sampling opcode is safe.
            S_MEM_ADDR: begin
                if (bus.opcode == OP_LOAD)       state_nxt = S_MEM_READ;
                else if (bus.opcode == OP_STORE) state_nxt = S_MEM_WRITE;
                else                             state_nxt = S_TRAP;
            end
            S_MEM_READ: begin
                if (stall_timeout)      state_nxt = S_TRAP;
                else if (bus.mem_ready) state_nxt = S_MEM_WB;
            end
            S_MEM_WRITE: begin
                if (stall_timeout)      state_nxt = S_TRAP;
                else if (bus.mem_ready) state_nxt = S_FETCH;
            end
            S_MEM_WB:    state_nxt = S_FETCH;
            S_EXECUTE:   state_nxt = S_ALU_WB;
            S_ALU_WB:    state_nxt = S_FETCH;
            S_BRANCH:    state_nxt = S_FETCH;
            S_TRAP:      state_nxt = S_TRAP;
            default:     state_nxt = S_RESET;
        endcase
    end

    // Output decode from the state register; unlisted controls stay low.
    always_comb begin
        cs = '0;
        case (state)
            S_FETCH: begin
                cs.mem_read  = 1'b1;
                cs.alu_src_b = SRCB_FOUR;
                cs.alu_op    = ALUOP_ADD;
                cs.ir_write  = bus.mem_ready;
                cs.pc_write  = bus.mem_ready;
            end
            S_DECODE: begin
                cs.alu_src_b = SRCB_BOFF;
                cs.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR: begin
                cs.alu_src_a = 1'b1;
                cs.alu_src_b = SRCB_IMM;
                cs.alu_op    = ALUOP_ADD;
            end
            S_MEM_READ: begin
                cs.mem_read = 1'b1;
                cs.i_or_d   = 1'b1;
            end
            S_MEM_WRITE: begin
                cs.mem_write = 1'b1;
                cs.i_or_d    = 1'b1;
            end
            S_MEM_WB: begin
                cs.reg_write  = 1'b1;
                cs.mem_to_reg = 1'b1;
            end
            S_EXECUTE: begin
                cs.alu_src_a = 1'b1;
                cs.alu_src_b = SRCB_REG;
                cs.alu_op    = ALUOP_FUNCT;
            end
            S_ALU_WB: begin
                cs.reg_write = 1'b1;
            end
            S_BRANCH: begin
                cs.alu_src_a     = 1'b1;
                cs.alu_src_b     = SRCB_REG;
                cs.alu_op        = ALUOP_SUB;
                cs.pc_write_cond = 1'b1;
                cs.pc_source     = 1'b1;
            end
            S_TRAP: begin
                cs.trap = 1'b1;
            end
            default: cs = '0;
        endcase
    end

    assign bus.pc_write      = cs.pc_write;
    assign bus.pc_write_cond = cs.pc_write_cond;
    assign bus.i_or_d        = cs.i_or_d;
    assign bus.mem_read      = cs.mem_read;
    assign bus.mem_write     = cs.mem_write;
    assign bus.ir_write      = cs.ir_write;
    assign bus.mem_to_reg    = cs.mem_to_reg;
    assign bus.reg_write     = cs.reg_write;
    assign bus.alu_src_a     = cs.alu_src_a;
    assign bus.alu_src_b     = cs.alu_src_b;
    assign bus.ctrl_ALU_op   = cs.alu_op;
    assign bus.pc_source     = cs.pc_source;
    assign bus.trap          = cs.trap;

`ifdef CTRL_PERF_CNT_EN
    logic retire;

    // An instruction retires when its last state hands back to FETCH.
    assign retire = (state_nxt == S_FETCH) &&
                    ((state == S_MEM_WB) || (state == S_MEM_WRITE) ||
                     (state == S_ALU_WB) || (state == S_BRANCH));

    // Free-running counters, wrapping, idle in reset and trap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            if ((state != S_RESET) && (state != S_TRAP)) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
            if (retire) begin
                instr_cnt <= instr_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
Main control unit for the multicycle RV64 core subset (ld, sd, add/sub/and/or, beq). It is the producer of ctrl_ALU_op (2'b00 add for address/PC, 2'b01 sub for compare, 2'b10 funct-decode) that the ALU control decoder consumes. It also produces every datapath enable and mux select per cycle. Moore FSM with memory-ready stalls and an illegal-opcode trap.

Parameters:
MEM_TIMEOUT, 16, max consecutive stall cycles waiting for mem_ready before trap; 0 disables the timeout
CNT_W, 32, width of performance counters (used only with the optional feature)

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
opcode  input  7  instruction register bits [6:0], valid from DECODE onward
mem_ready  input  1  memory completes the access this cycle
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load qualified by the datapath zero flag
i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  instruction register load
mem_to_reg  output  1  write-back select: 0 = ALUOut, 1 = MDR
reg_write  output  1  register file write enable
alu_src_a  output  1  0 = PC, 1 = register A
alu_src_b  output  2  00 = B, 01 = const 4, 10 = immediate, 11 = branch offset (imm<<1)
ctrl_ALU_op  output  2  to ALU control decoder
pc_source  output  1  0 = ALU result, 1 = ALUOut
trap  output  1  sticky illegal-opcode / timeout indication

Behaviour:
- Reset is asynchronous and active-low on rst_n; the clock is clk. While rst_n = 0: state = S_RESET and every output is 0, including trap. S_RESET always goes to FETCH on the next edge.
- Outputs are decoded combinationally from the state register only (pure Moore); opcode affects only the next state.
- Any output not listed for a state is 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, ctrl_ALU_op=00.
  - ir_write and pc_write equal mem_ready, so the IR and PC update only on the completing cycle.
  - mem_ready=1 -> DECODE; otherwise stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, ctrl_ALU_op=00 (branch target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> MEM_ADDR
  - 0110011 -> EXECUTE
  - 1100011 -> BRANCH
  - any other value -> TRAP
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ctrl_ALU_op=00. Next: ld -> MEM_READ, sd -> MEM_WRITE. The opcode is re-sampled here; the IR is stable.
- MEM_READ: mem_read=1, i_or_d=1. mem_ready -> MEM_WB, else stay.
- MEM_WRITE: mem_write=1, i_or_d=1. mem_ready -> FETCH, else stay.
- MEM_WB: reg_write=1, mem_to_reg=1. Next FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, ctrl_ALU_op=10. Next ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0. Next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, ctrl_ALU_op=01, pc_write_cond=1, pc_source=1. Next FETCH.
- TRAP: trap=1, all other outputs 0. Terminal; only reset exits.
- Cycles per instruction with zero-wait memory: ld 5, sd 4, R-type 4, beq 3.
- Stall counter:
  - Counts consecutive cycles in FETCH / MEM_READ / MEM_WRITE with mem_ready=0, saturating.
  - Cleared on any state change.
  - When MEM_TIMEOUT != 0 and the count reaches MEM_TIMEOUT -> TRAP on the next edge.
- mem_read and mem_write are never both 1.
- reset asserted mid-access drops all requests immediately (asynchronous).

Optional Feature:
CTRL_PERF_CNT_EN
- Defined:
  - Adds outputs cycle_cnt[CNT_W-1:0] and instr_cnt[CNT_W-1:0], both reset to 0.
  - cycle_cnt increments every cycle outside S_RESET and TRAP.
  - instr_cnt increments on each transition into FETCH from MEM_WB, MEM_WRITE, ALU_WB or BRANCH.
  - Both wrap modulo 2^CNT_W.
- Undefined: the ports and logic are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package: the ctrl_state_t enum; the opcode constants OP_LOAD, OP_STORE, OP_RTYPE, OP_BRANCH; the ALU_op constants ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10; the alu_src_b encodings.
- One natural sub-module: ctrl_stall_timer (saturating stall counter and timeout flag).

Test Plan:
- Reset release, mem_ready tied 1, opcode=0110011: states FETCH, DECODE, EXECUTE, ALU_WB. ctrl_ALU_op=10 in EXECUTE; reg_write=1 only in ALU_WB; instruction takes 4 cycles.
- opcode=0000011, mem_ready low for 3 cycles in MEM_READ: mem_read and i_or_d held at 1 for 4 cycles; MEM_WB asserts reg_write=1 with mem_to_reg=1.
- opcode=0100011: MEM_WRITE asserts mem_write=1 and mem_read=0, then returns to FETCH; reg_write is never 1.
- opcode=1100011: BRANCH state shows ctrl_ALU_op=01, pc_write_cond=1, pc_source=1; next state is FETCH.
- opcode=0010011 (unsupported): TRAP one cycle after DECODE, trap=1 held for 20 cycles. Separately, mem_ready held 0 in FETCH for 16 cycles traps with MEM_TIMEOUT=16.
- Assert rst_n=0 in MEM_READ mid-stall: all outputs 0 with no clock edge; after release, S_RESET then FETCH, and trap is cleared.
